uart_param: RTL



---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/uart_param.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM state
// encodings and small helper functions used by both TX and RX.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Number of bit periods in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
        return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

    // Parity of a zero-extended payload; zero padding does not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter that parks at zero; tick_o is high while the count is zero.
// A load of N-1 therefore yields a tick on the N-th cycle after the load.
module uart_baud_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: independent TX and RX engines in one clock domain.
// TX handshake: a request is taken on a cycle where tx_valid and tx_ready are both
// high; tx_data is captured then and later changes are ignored until tx_ready returns.
module uart_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 7,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_done,
    output logic              s_out,
    input  logic              s_in,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic [2:0]        dbg_tx_state,
    output logic [2:0]        dbg_rx_state
);

    localparam int CNT_W      = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int FRAME_BITS = frame_bits(DATA_W, PARITY, STOP_BITS);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam bit HAS_PAR    = (PARITY != PAR_NONE);

    localparam logic [CNT_W-1:0] LOAD_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    // Stop period is one cycle short on the counter: the extra cycle is the
    // tx_done cycle, spent with the counter parked at zero.
    localparam logic [CNT_W-1:0] LOAD_STOP = CNT_W'(STOP_BITS * CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

    // ---------------- TX engine ----------------
    tx_state_e         tx_state_q;
    logic              tx_ready_q, tx_done_q, s_out_q, tx_par_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [BIT_W-1:0]  tx_bit_q;
    logic              tx_load, tx_tick;
    logic [CNT_W-1:0]  tx_load_val;

    // Baud counter reload points for TX: on accept and at every bit boundary.
    always_comb begin
        tx_load     = 1'b0;
        tx_load_val = LOAD_BIT;
        case (tx_state_q)
            TX_IDLE:   tx_load = tx_valid && tx_ready_q;
            TX_START:  tx_load = tx_tick;
            TX_DATA: begin
                tx_load = tx_tick;
                if (tx_bit_q == LAST_BIT && !HAS_PAR) tx_load_val = LOAD_STOP;
            end
            TX_PARITY: begin
                tx_load     = tx_tick;
                tx_load_val = LOAD_STOP;
            end
            default: ;
        endcase
    end

    uart_baud_cnt #(.CNT_W(CNT_W)) u_tx_cnt (
        .clk        (clk),
        .rstN       (rstN),
        .load_i     (tx_load),
        .load_val_i (tx_load_val),
        .tick_o     (tx_tick)
    );

    // TX state machine with registered line, ready and done outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tx_state_q <= TX_IDLE;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
            s_out_q    <= 1'b1;
            tx_par_q   <= 1'b0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        tx_shift_q <= tx_data;
                        tx_par_q   <= parity_bit(9'(tx_data), PARITY);
                        tx_ready_q <= 1'b0;
                        s_out_q    <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        s_out_q    <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit_q == LAST_BIT) begin
                            s_out_q    <= HAS_PAR ? tx_par_q : 1'b1;
                            tx_state_q <= HAS_PAR ? TX_PARITY : TX_STOP;
                        end else begin
                            s_out_q    <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_bit_q   <= tx_bit_q + BIT_W'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_tick) begin
                        s_out_q    <= 1'b1;
                        tx_state_q <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        if (!tx_done_q) begin
                            tx_done_q <= 1'b1;
                        end else begin
                            tx_ready_q <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_ready     = tx_ready_q;
    assign tx_done      = tx_done_q;
    assign s_out        = s_out_q;
    assign dbg_tx_state = tx_state_q;

    // ---------------- RX engine ----------------
    rx_state_e         rx_state_q;
    logic [1:0]        rx_sync_q;
    logic              rx_bit;
    logic              rx_valid_q, rx_perr_q, rx_ferr_q, rx_par_q;
    logic [DATA_W-1:0] rx_shift_q, rx_data_q;
    logic [BIT_W-1:0]  rx_bit_q;
    logic              rx_load, rx_tick;
    logic [CNT_W-1:0]  rx_load_val;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) rx_sync_q <= 2'b11;
        else       rx_sync_q <= {rx_sync_q[0], s_in};
    end

    assign rx_bit = rx_sync_q[1];

    // Baud counter reload points for RX: half a bit to centre, then full bits.
    always_comb begin
        rx_load     = 1'b0;
        rx_load_val = LOAD_BIT;
        case (rx_state_q)
            RX_IDLE: begin
                rx_load     = !rx_bit;
                rx_load_val = LOAD_HALF;
            end
            RX_START:  rx_load = rx_tick && !rx_bit;
            RX_DATA:   rx_load = rx_tick;
            RX_PARITY: rx_load = rx_tick;
            default: ;
        endcase
    end

    uart_baud_cnt #(.CNT_W(CNT_W)) u_rx_cnt (
        .clk        (clk),
        .rstN       (rstN),
        .load_i     (rx_load),
        .load_val_i (rx_load_val),
        .tick_o     (rx_tick)
    );

    // RX state machine: mid-bit sampling, result and error flags registered together.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_state_q <= RX_IDLE;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_par_q   <= 1'b0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_bit_q   <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_bit) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_tick) begin
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_bit ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift_q <= {rx_bit, rx_shift_q[DATA_W-1:1]};
                        if (rx_bit_q == LAST_BIT) begin
                            rx_state_q <= HAS_PAR ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + BIT_W'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_tick) begin
                        rx_par_q   <= rx_bit;
                        rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_shift_q;
                        rx_perr_q  <= HAS_PAR && (rx_par_q != parity_bit(9'(rx_shift_q), PARITY));
                        rx_ferr_q  <= !rx_bit;
                        rx_state_q <= rx_bit ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_bit) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign dbg_rx_state  = rx_state_q;

endmodule
